// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Imported by the arbiter top, its watchdog and the bench.
package mem_bus_arbiter_pkg;

   localparam int DefAw      = 32;
   localparam int DefDw      = 32;
   localparam int WdtTimeout = 15;

   // Byte-enable pattern presented on the bus for every instruction fetch.
   localparam logic [DefDw/8-1:0] SelAllOnes = '1;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbBusI = 2'd1,
      ArbBusD = 2'd2,
      ArbAck  = 2'd3
   } arb_state_t;

   // Counter width able to hold 0..limit, never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch, data) and the
// shared memory bus. master = arbiter view, slave = environment view.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // Requester handshake: x_req and all of its fields stay stable until the
   // one-cycle x_ack; in the cycle after x_ack the requester either drops
   // x_req or presents a new request. Bus handshake: bus_cyc/bus_stb stay
   // high with stable fields until the slave raises bus_ack for one cycle.

   logic            i_req;
   logic [AW-1:0]   i_addr;
   logic [DW-1:0]   i_rdata;
   logic            i_ack;

   logic            d_req;
   logic            d_we;
   logic [DW/8-1:0] d_sel;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW-1:0]   d_rdata;
   logic            d_ack;

   logic            bus_cyc;
   logic            bus_stb;
   logic            bus_we;
   logic [DW/8-1:0] bus_sel;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata;
   logic [DW-1:0]   bus_rdata;
   logic            bus_ack;

   logic            stallreq_if;
   logic            stallreq_mem;
   logic            err_o;
   logic [AW-1:0]   err_addr;

   modport master (
      input  i_req, i_addr,
      output i_rdata, i_ack,
      input  d_req, d_we, d_sel, d_addr, d_wdata,
      output d_rdata, d_ack,
      output bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack,
      output stallreq_if, stallreq_mem, err_o, err_addr
   );

   modport slave (
      output i_req, i_addr,
      input  i_rdata, i_ack,
      output d_req, d_we, d_sel, d_addr, d_wdata,
      input  d_rdata, d_ack,
      input  bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
      output bus_rdata, bus_ack,
      input  stallreq_if, stallreq_mem, err_o, err_addr
   );

endinterface

// File: rtl/mem_bus_arbiter_bus_wdt.sv
// Bus-phase watchdog: counts strobe cycles while enabled and flags expiry on
// the cycle the count reaches TIMEOUT. TIMEOUT = 0 disables it.
module mem_bus_arbiter_bus_wdt
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = WdtTimeout
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt;

   generate
      if (TIMEOUT > 0) begin : g_wdt
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (en) begin
               cnt <= cnt + 1'b1;
            end
         end

         // Expiry is decided on the strobe cycle whose increment brings cnt to
         // TIMEOUT, so the bus phase lasts exactly TIMEOUT strobe cycles.
         assign expire = en && (cnt == CW'(TIMEOUT - 1));
      end else begin : g_off
         logic unused_off;

         assign cnt        = '0;
         assign expire     = 1'b0;
         assign unused_off = ^{clk, rst, clr, en, cnt};
      end
   endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style memory bus between the fetch and data ports, one
// transaction at a time, data port first; aborts unacknowledged bus phases.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW      = DefAw,
   parameter int DW      = DefDw,
   parameter int TIMEOUT = WdtTimeout
) (
   input  logic                     clk,
   input  logic                     rst,
   mem_bus_arbiter_if.master        bus_if,
   output arb_state_t               dbg_state
);

   arb_state_t      state;
   arb_state_t      state_next;

   logic            grant_i;
   logic            grant_d;
   logic            done_ack;
   logic            done_abort;
   logic            in_bus;
   logic            wdt_expire;

   logic            cyc_r;
   logic            we_r;
   logic [DW/8-1:0] sel_r;
   logic [AW-1:0]   addr_r;
   logic [DW-1:0]   wdata_r;
   logic [DW-1:0]   i_rdata_r;
   logic [DW-1:0]   d_rdata_r;
   logic            i_ack_r;
   logic            d_ack_r;
   logic            err_r;
   logic [AW-1:0]   err_addr_r;

   assign in_bus = (state == ArbBusI) || (state == ArbBusD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ArbIdle;
      end else begin
         state <= state_next;
      end
   end

   // Requests are only sampled in IDLE, so a request still held during the
   // ACK cycle cannot start a second bus cycle.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      done_ack   = 1'b0;
      done_abort = 1'b0;
      case (state)
         ArbIdle: begin
            if (bus_if.d_req) begin
               grant_d    = 1'b1;
               state_next = ArbBusD;
            end else if (bus_if.i_req) begin
               grant_i    = 1'b1;
               state_next = ArbBusI;
            end
         end
         ArbBusI, ArbBusD: begin
            if (bus_if.bus_ack) begin
               done_ack   = 1'b1;
               state_next = ArbAck;
            end else if (wdt_expire) begin
               done_abort = 1'b1;
               state_next = ArbAck;
            end
         end
         ArbAck: begin
            state_next = ArbIdle;
         end
         default: begin
            state_next = ArbIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_r      <= 1'b0;
         we_r       <= 1'b0;
         sel_r      <= '0;
         addr_r     <= '0;
         wdata_r    <= '0;
         i_rdata_r  <= '0;
         d_rdata_r  <= '0;
         i_ack_r    <= 1'b0;
         d_ack_r    <= 1'b0;
         err_r      <= 1'b0;
         err_addr_r <= '0;
      end else begin
         i_ack_r <= 1'b0;
         d_ack_r <= 1'b0;
         err_r   <= 1'b0;

         if (grant_d) begin
            cyc_r   <= 1'b1;
            we_r    <= bus_if.d_we;
            sel_r   <= bus_if.d_sel;
            addr_r  <= bus_if.d_addr;
            wdata_r <= bus_if.d_wdata;
         end else if (grant_i) begin
            cyc_r   <= 1'b1;
            we_r    <= 1'b0;
            sel_r   <= {(DW/8){1'b1}};
            addr_r  <= bus_if.i_addr;
            wdata_r <= '0;
         end

         // Completion: the served port gets its data (zero on abort) and a
         // single ack pulse during the ACK state.
         if (done_ack || done_abort) begin
            cyc_r <= 1'b0;
            we_r  <= 1'b0;
            if (state == ArbBusD) begin
               d_ack_r   <= 1'b1;
               d_rdata_r <= done_ack ? bus_if.bus_rdata : '0;
            end else begin
               i_ack_r   <= 1'b1;
               i_rdata_r <= done_ack ? bus_if.bus_rdata : '0;
            end
         end

         if (done_abort) begin
            err_r      <= 1'b1;
            err_addr_r <= addr_r;
         end
      end
   end

   mem_bus_arbiter_bus_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_bus_wdt (
      .clk    (clk),
      .rst    (rst),
      .clr    (!in_bus),
      .en     (in_bus),
      .expire (wdt_expire)
   );

   assign bus_if.bus_cyc      = cyc_r;
   assign bus_if.bus_stb      = cyc_r;
   assign bus_if.bus_we       = we_r;
   assign bus_if.bus_sel      = sel_r;
   assign bus_if.bus_addr     = addr_r;
   assign bus_if.bus_wdata    = wdata_r;
   assign bus_if.i_rdata      = i_rdata_r;
   assign bus_if.i_ack        = i_ack_r;
   assign bus_if.d_rdata      = d_rdata_r;
   assign bus_if.d_ack        = d_ack_r;
   assign bus_if.err_o        = err_r;
   assign bus_if.err_addr     = err_addr_r;

   // Stall requests see the registered acks, so they fall in the ack cycle.
   assign bus_if.stallreq_if  = bus_if.i_req & ~i_ack_r;
   assign bus_if.stallreq_mem = bus_if.d_req & ~d_ack_r;

   assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, data priority, waited store,
// watchdog abort, async reset mid-transaction, back-to-back and stray ack.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic        clk;
   logic        rst;
   arb_state_t  dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_e;

   int          slave_wait;
   logic        slave_never;
   logic        slave_stray;
   logic [3:0]  wcnt = '0;
   int          n_starts = 0;
   int          starts0;
   logic        stb_q = 1'b0;

   mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bif ();

   mem_bus_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_if    (bif),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   function automatic logic [31:0] rd_of(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h3402_0020;
         32'h0000_0104: return 32'h0000_0013;
         32'h0000_0108: return 32'h0010_0093;
         32'h0000_0200: return 32'hDEAD_BEEF;
         default:       return a ^ 32'hA5A5_A5A5;
      endcase
   endfunction

   assign bif.bus_rdata = rd_of(bif.bus_addr);
   assign bif.bus_ack   = slave_stray |
                          (bif.bus_stb & ~slave_never & (int'(wcnt) == slave_wait));

   always @(posedge clk) begin
      if (!bif.bus_stb || bif.bus_ack) wcnt <= '0;
      else                             wcnt <= wcnt + 1'b1;
      if (bif.bus_stb && !stb_q) n_starts <= n_starts + 1;
      stb_q <= bif.bus_stb;
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard: every ack pops one expected {is_data, rdata} ----------------
   always @(negedge clk) begin
      if (rst && (bif.i_ack || bif.d_ack)) begin
         check("ack_one_port", {63'd0, bif.i_ack & bif.d_ack}, 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", {62'd0, bif.i_ack, bif.d_ack}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_data", {31'd0, bif.d_ack, bif.d_ack ? bif.d_rdata : bif.i_rdata},
                  {31'd0, mon_e});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic fetch_req(input logic [31:0] a);
      bif.i_req  = 1'b1;
      bif.i_addr = a;
   endtask

   task automatic data_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] wd);
      bif.d_req   = 1'b1;
      bif.d_we    = we;
      bif.d_sel   = sel;
      bif.d_addr  = a;
      bif.d_wdata = wd;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst         = 1'b1;
      bif.i_req   = 1'b0;
      bif.i_addr  = '0;
      bif.d_req   = 1'b0;
      bif.d_we    = 1'b0;
      bif.d_sel   = '0;
      bif.d_addr  = '0;
      bif.d_wdata = '0;
      slave_wait  = 0;
      slave_never = 1'b0;
      slave_stray = 1'b0;
      #1 rst = 1'b0;
      step(); step(); smp();
      check("rst_state", dbg_state, ArbIdle);
      check("rst_bus_ctl", {bif.bus_cyc, bif.bus_stb, bif.bus_we, bif.bus_sel}, 0);
      check("rst_bus_addr", {bif.bus_addr, bif.bus_wdata}, 0);
      check("rst_rdata", {bif.i_rdata, bif.d_rdata}, 0);
      check("rst_acks_err", {bif.i_ack, bif.d_ack, bif.err_o}, 0);
      check("rst_err_addr", bif.err_addr, 0);
      step(); rst = 1'b1;
      step(); smp();
      check("idle_after_rst", dbg_state, ArbIdle);

      // Fetch only, zero-wait slave
      exp_q.push_back({1'b0, 32'h3402_0020});
      step(); fetch_req(32'h100);
      smp();
      check("t1_c0_stall_if", bif.stallreq_if, 1);
      check("t1_c0_stb", bif.bus_stb, 0);
      step(); smp();
      check("t1_c1_cyc_stb", {bif.bus_cyc, bif.bus_stb}, 2'b11);
      check("t1_c1_addr", bif.bus_addr, 32'h100);
      check("t1_c1_sel", bif.bus_sel, SelAllOnes);
      check("t1_c1_we", bif.bus_we, 0);
      check("t1_c1_iack", bif.i_ack, 0);
      step(); smp();
      check("t1_c2_iack", bif.i_ack, 1);
      check("t1_c2_rdata", bif.i_rdata, 32'h3402_0020);
      check("t1_c2_stall_if", bif.stallreq_if, 0);
      check("t1_c2_stb", bif.bus_stb, 0);
      check("t1_c2_state", dbg_state, ArbAck);
      step(); bif.i_req = 1'b0;
      smp();
      check("t1_c3_iack", bif.i_ack, 0);
      check("t1_c3_state", dbg_state, ArbIdle);
      check("t1_c3_rdata_hold", bif.i_rdata, 32'h3402_0020);

      // Simultaneous fetch and load: data wins
      exp_q.push_back({1'b1, 32'hDEAD_BEEF});
      exp_q.push_back({1'b0, 32'h0000_0013});
      step(); fetch_req(32'h104); data_req(1'b0, 4'hF, 32'h200, 32'h0);
      smp();
      check("t2_c0_state", dbg_state, ArbIdle);
      step(); smp();
      check("t2_c1_addr", bif.bus_addr, 32'h200);
      check("t2_c1_stb", bif.bus_stb, 1);
      check("t2_c1_stalls", {bif.stallreq_if, bif.stallreq_mem}, 2'b11);
      step(); smp();
      check("t2_c2_dack", {bif.d_ack, bif.i_ack}, 2'b10);
      check("t2_c2_drdata", bif.d_rdata, 32'hDEAD_BEEF);
      check("t2_c2_stalls", {bif.stallreq_if, bif.stallreq_mem}, 2'b10);
      step(); bif.d_req = 1'b0;
      smp();
      check("t2_c3_state", dbg_state, ArbIdle);
      check("t2_c3_stb", bif.bus_stb, 0);
      check("t2_c3_stall_if", bif.stallreq_if, 1);
      step(); smp();
      check("t2_c4_stb", bif.bus_stb, 1);
      check("t2_c4_addr", bif.bus_addr, 32'h104);
      check("t2_c4_stall_if", bif.stallreq_if, 1);
      step(); smp();
      check("t2_c5_iack", bif.i_ack, 1);
      check("t2_c5_rdata", bif.i_rdata, 32'h0000_0013);
      check("t2_c5_stall_if", bif.stallreq_if, 0);
      step(); bif.i_req = 1'b0;

      // Store with 3 wait states; ack coincides with watchdog expiry
      exp_q.push_back({1'b1, 32'hA5A5_A6A5});
      step(); slave_wait = 3; data_req(1'b1, 4'b0011, 32'h300, 32'h1234_5678);
      smp();
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 2) bif.d_wdata = 32'hFFFF_FFFF;
         smp();
         check($sformatf("t3_c%0d_stb_we", k), {bif.bus_stb, bif.bus_we}, 2'b11);
         check($sformatf("t3_c%0d_sel", k), bif.bus_sel, 4'b0011);
         check($sformatf("t3_c%0d_wdata", k), bif.bus_wdata, 32'h1234_5678);
         check($sformatf("t3_c%0d_dack", k), bif.d_ack, 0);
      end
      step(); smp();
      check("t3_c5_dack", bif.d_ack, 1);
      check("t3_c5_stb", bif.bus_stb, 0);
      check("t3_c5_no_err", bif.err_o, 0);
      check("t3_c5_state", dbg_state, ArbAck);
      step(); bif.d_req = 1'b0; bif.d_we = 1'b0; slave_wait = 0;

      // Watchdog abort on a slave that never acks
      exp_q.push_back({1'b1, 32'h0});
      step(); slave_never = 1'b1; data_req(1'b0, 4'hF, 32'h400, 32'h0);
      smp();
      for (int k = 1; k <= 4; k++) begin
         step(); smp();
         check($sformatf("t4_c%0d_stb", k), bif.bus_stb, 1);
         check($sformatf("t4_c%0d_err", k), bif.err_o, 0);
      end
      step(); smp();
      check("t4_c5_stb", bif.bus_stb, 0);
      check("t4_c5_err", bif.err_o, 1);
      check("t4_c5_err_addr", bif.err_addr, 32'h400);
      check("t4_c5_dack", bif.d_ack, 1);
      check("t4_c5_drdata", bif.d_rdata, 32'h0);
      step(); bif.d_req = 1'b0; slave_never = 1'b0;
      smp();
      check("t4_c6_err", bif.err_o, 0);
      check("t4_c6_err_addr", bif.err_addr, 32'h400);
      check("t4_c6_state", dbg_state, ArbIdle);
      exp_q.push_back({1'b0, 32'h0010_0093});
      step(); fetch_req(32'h108);
      smp();
      step(); smp();
      check("t4_f1_stb", bif.bus_stb, 1);
      step(); smp();
      check("t4_f2_iack", bif.i_ack, 1);
      check("t4_f2_rdata", bif.i_rdata, 32'h0010_0093);
      step(); bif.i_req = 1'b0;

      // Asynchronous reset in the middle of a waited load
      step(); slave_wait = 3; data_req(1'b0, 4'hF, 32'h500, 32'h0);
      smp();
      step(); smp();
      check("t5_c1_stb", bif.bus_stb, 1);
      check("t5_c1_state", dbg_state, ArbBusD);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_cyc_stb", {bif.bus_cyc, bif.bus_stb}, 2'b00);
      check("t5_rst_state", dbg_state, ArbIdle);
      check("t5_rst_irdata", bif.i_rdata, 32'h0);
      check("t5_rst_dack", bif.d_ack, 0);
      bif.d_req = 1'b0;
      step(); rst = 1'b1; slave_wait = 0;
      smp();
      check("t5_rel_state", dbg_state, ArbIdle);
      check("t5_rel_cyc", bif.bus_cyc, 0);
      step(); smp();
      check("t5_rel_no_ack", {bif.d_ack, bif.i_ack}, 2'b00);
      exp_q.push_back({1'b0, 32'hA5A5_A4A9});
      step(); fetch_req(32'h10C);
      smp();
      step(); smp();
      check("t5_f1_stb", bif.bus_stb, 1);
      check("t5_f1_addr", bif.bus_addr, 32'h10C);
      step(); smp();
      check("t5_f2_iack", bif.i_ack, 1);
      check("t5_f2_rdata", bif.i_rdata, 32'hA5A5_A4A9);
      step(); bif.i_req = 1'b0;

      // Requester holds i_req across i_ack and switches address
      starts0 = n_starts;
      exp_q.push_back({1'b0, 32'hA5A5_A4B5});
      exp_q.push_back({1'b0, 32'hA5A5_A4B1});
      step(); fetch_req(32'h110);
      smp();
      step(); smp();
      step(); smp();
      check("t6_a_iack", bif.i_ack, 1);
      check("t6_a_rdata", bif.i_rdata, 32'hA5A5_A4B5);
      step(); bif.i_addr = 32'h114;
      smp();
      check("t6_idle_state", dbg_state, ArbIdle);
      check("t6_idle_ack_stb", {bif.i_ack, bif.bus_stb}, 2'b00);
      step(); smp();
      check("t6_b_stb", bif.bus_stb, 1);
      check("t6_b_addr", bif.bus_addr, 32'h114);
      step(); smp();
      check("t6_b_iack", bif.i_ack, 1);
      check("t6_b_rdata", bif.i_rdata, 32'hA5A5_A4B1);
      step(); bif.i_req = 1'b0;
      smp();
      check("t6_end_state", dbg_state, ArbIdle);
      step(); smp();
      check("t6_bus_cycles", n_starts - starts0, 2);

      // Stray bus_ack while idle is ignored
      step(); slave_stray = 1'b1;
      smp();
      check("t7_state", dbg_state, ArbIdle);
      check("t7_stb", bif.bus_stb, 0);
      step(); slave_stray = 1'b0;
      smp();
      check("t7_after_state", dbg_state, ArbIdle);
      check("t7_after_acks", {bif.i_ack, bif.d_ack}, 2'b00);
      check("t7_irdata_hold", bif.i_rdata, 32'hA5A5_A4B1);

      step(); smp();
      check("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares a single Wishbone-style memory bus between the instruction-fetch port (driven by `pc_reg`/`if_id`) and the data port (driven by the `mem` stage). It sequences one bus transaction at a time through an FSM with fixed data priority, returns read data with a one-cycle acknowledge pulse, and raises per-stage stall requests for the pipeline controller. A watchdog aborts transactions the slave never acknowledges.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (`RegBus`)
- `TIMEOUT`, 15, max cycles in a bus phase before abort; 0 disables the watchdog

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_ack`
- `i_addr`  in  AW  fetch address
- `i_rdata`  out  DW  fetched word, valid while `i_ack`=1
- `i_ack`  out  1  one-cycle fetch done pulse
- `d_req`  in  1  data request; held with `d_we`, `d_sel`, `d_addr`, `d_wdata` until `d_ack`
- `d_we`  in  1  1 = write
- `d_sel`  in  DW/8  byte enables
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_rdata`  out  DW  load data, valid while `d_ack`=1
- `d_ack`  out  1  one-cycle data done pulse
- `bus_cyc`, `bus_stb`  out  1  bus cycle/strobe
- `bus_we`  out  1  bus write enable
- `bus_sel`  out  DW/8  bus byte enables (all ones for fetch)
- `bus_addr`  out  AW  bus address
- `bus_wdata`  out  DW  bus write data
- `bus_rdata`  in  DW  slave read data
- `bus_ack`  in  1  slave acknowledge
- `stallreq_if`  out  1  `i_req & ~i_ack`
- `stallreq_mem`  out  1  `d_req & ~d_ack`
- `err_o`  out  1  one-cycle pulse on watchdog abort
- `err_addr`  out  AW  address of last aborted transaction

## Operation
- States: IDLE, BUS_I, BUS_D, ACK.
- IDLE: `d_req` → BUS_D (latch d_* fields); else `i_req` → BUS_I (latch `i_addr`); else stay. Data always wins when both are pending.
- BUS_x: `bus_cyc`=`bus_stb`=1, bus fields from latched request; watchdog counter increments each cycle. On `bus_ack`: latch `bus_rdata` into the served port's rdata register, → ACK. If the counter reaches `TIMEOUT` without `bus_ack`: drop the bus, rdata := 0, `err_o`=1 for one cycle, `err_addr` := latched address, → ACK.
- ACK: assert the served port's `x_ack` for exactly one cycle, → IDLE. The counter clears on entry to IDLE.
- Requester rule: after seeing `x_ack`, the requester drops `x_req` or presents a new request in the next cycle. The arbiter samples only in IDLE, so a held request is never served twice.
- Requests are latched at grant. Changes to the requester's inputs during BUS_x are ignored.
- The rdata registers hold their value until the next completion on the same port.
- Writes return `d_rdata` = `bus_rdata` as sampled. Software ignores it.

## Timing
- All outputs are registered except `stallreq_if` and `stallreq_mem`, which are combinational.
- Reset (`rst`=0) takes effect immediately: state IDLE, `bus_cyc`/`bus_stb`/`bus_we`=0, `bus_sel`/`bus_addr`/`bus_wdata`=0, both rdata=0, both ack=0, `err_o`=0, `err_addr`=0, counter 0. A reset mid-transaction drops `bus_cyc` without waiting for `bus_ack`.
- Latency with a zero-wait slave: request seen in IDLE at cycle 0, strobe in cycle 1, ack pulse in cycle 2, IDLE in cycle 3. That is 3 cycles per transaction, plus one cycle for each slave wait state.
- A `bus_ack` arriving outside BUS_x is ignored.
- If `bus_ack` and the timeout coincide, `bus_ack` wins and no error is flagged.
- Abort occurs on the cycle the counter equals `TIMEOUT`, i.e. after `TIMEOUT` strobe cycles.

## Structure
- Shared constants go in `defines.v`: state encodings (`ArbIdle`, `ArbBusI`, `ArbBusD`, `ArbAck`), `WdtTimeout` default, and byte-enable all-ones constant.
- One sub-module, `bus_wdt`: a counter with clear/enable inputs and an expire output, parameterised by `TIMEOUT`. With `TIMEOUT`=0 it never expires.

## Test plan
- Fetch only: `i_req`, `i_addr`=0x100, zero-wait slave returns 0x3402_0020 → `bus_stb` in cycle 1, `i_ack`=1 with `i_rdata`=0x3402_0020 in cycle 2, `stallreq_if` low from cycle 2.
- Simultaneous `i_req` and `d_req` (load from 0x200 returning 0xDEAD_BEEF) → data is served first (`d_ack` in cycle 2), fetch strobes in cycle 4 and `i_ack` arrives in cycle 5. `stallreq_if` stays high through cycle 4.
- Store: `d_we`=1, `d_sel`=4'b0011, `d_wdata`=0x1234_5678, slave with 3 wait states → `bus_we`=1 and `bus_sel`=0011 held for 4 strobe cycles, `d_ack` one cycle after `bus_ack`.
- Timeout with `TIMEOUT`=4 and a slave that never acks `d_addr`=0x400 → strobe for 4 cycles, `err_o` pulse, `err_addr`=0x400, `d_ack` with `d_rdata`=0, then a following fetch completes normally.
- Reset pulse during BUS_D with wait states → `bus_cyc` drops asynchronously, no ack is issued, and after release a new `i_req` is served from IDLE.
- Back-to-back requester holding `i_req` across `i_ack` with a new address → exactly one ack per address, no duplicate bus cycle.
